// File: rtl/dac_sample_scheduler.sv
// Paces samples from a small FIFO to a DAC datapath at one sample every osr_i+1 clocks,
// with a priming phase before output starts and a sticky underrun flag.
module dac_sample_scheduler #(
  parameter int BW        = 16,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [7:0]               osr_i,
  input  logic                     in_valid_i,
  input  logic [BW-1:0]            in_data_i,
  output logic                     in_ready_o,
  output logic [BW-1:0]            sample_o,
  output logic                     sample_stb_o,
  output logic                     underrun_o,
  input  logic                     clr_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] PRIME_L = PRIME_LVL[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [BW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       level_r;
  logic [7:0]        cnt_r;
  logic [BW-1:0]     sample_r;
  logic              stb_r;
  logic              under_r;
  logic              tick_s;
  logic              push_s;
  logic              pop_s;
  logic              under_s;
  logic              flush_s;

  // IDLE holds the FIFO empty, so it refuses pushes even while en_i is already high.
  assign in_ready_o = en_i && (state_r != IDLE) && (level_r < DEPTH_L);
  assign push_s     = in_valid_i && in_ready_o;
  assign flush_s    = !en_i || (state_r == IDLE);
  assign pop_s      = tick_s && en_i && (level_r != '0);
  assign under_s    = tick_s && en_i && (level_r == '0);

  // Next-state logic and the sample tick; the counter is 0 on RUN entry, so the first RUN cycle ticks.
  always_comb begin
    state_nxt_s = state_r;
    tick_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_i) state_nxt_s = PRIME;
        else      state_nxt_s = IDLE;
      end
      PRIME: begin
        if (!en_i)                   state_nxt_s = IDLE;
        else if (level_r >= PRIME_L) state_nxt_s = RUN;
        else                         state_nxt_s = PRIME;
      end
      RUN: begin
        if (cnt_r == 8'd0) tick_s = 1'b1;
        else               tick_s = 1'b0;
        if (!en_i) state_nxt_s = IDLE;
        else       state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // FIFO storage is left unreset; occupancy is tracked by level_r alone.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data_i;
  end

  // FIFO pointers/level, period counter and output sample register.
  always_ff @(posedge clk) begin
    if (rst_i || flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      cnt_r    <= 8'd0;
      sample_r <= '0;
      stb_r    <= 1'b0;
    end else begin
      stb_r <= pop_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        sample_r <= mem_r[rd_ptr_r];
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1'b1);
        2'b01:   level_r <= level_r - (AW+1)'(1'b1);
        default: level_r <= level_r;
      endcase
      if (state_r != RUN) cnt_r <= 8'd0;
      else if (tick_s)    cnt_r <= osr_i;
      else                cnt_r <= cnt_r - 8'd1;
    end
  end

  // Sticky underrun flag; a new underrun outranks a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst_i)        under_r <= 1'b0;
    else if (under_s) under_r <= 1'b1;
    else if (clr_i)   under_r <= 1'b0;
  end

  assign sample_o     = sample_r;
  assign sample_stb_o = stb_r;
  assign underrun_o   = under_r;
  assign level_o      = level_r;
  assign state_o      = state_r;

endmodule
